// File: rtl/axis_pixel_frame_packer_pkg.sv
// axis_pixel_frame_packer_pkg: shared FSM state type and frame geometry helpers.
package axis_pixel_frame_packer_pkg;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    function automatic int num_pix(input int r, input int c);
        return r * c;
    endfunction

    function automatic int w_out(input int r, input int c, input int w);
        return r * c * w;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_pixel_frame_packer_frame_idle_timer.sv
// frame_idle_timer: counts consecutive idle cycles of a partial frame and flags expiry.
module frame_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic idle_i,
    output logic expire_o
);

    logic [IW-1:0] idle_q, idle_d;

    // Expire on the edge that would bring the count to TIMEOUT_CYCLES.
    assign expire_o = idle_i && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    always_comb idle_d = (idle_i && !expire_o) ? idle_q + IW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) idle_q <= '0;
        else       idle_q <= idle_d;
    end

endmodule

// File: rtl/axis_pixel_frame_packer.sv
// axis_pixel_frame_packer: packs a raster stream of pixels into one wide AXIS frame word.
// Optional partial-frame discard on idle timeout under FRAME_TIMEOUT_EN.
module axis_pixel_frame_packer
    import axis_pixel_frame_packer_pkg::*;
#(
    parameter int R_I            = 7,
    parameter int C_I            = 7,
    parameter int W_I            = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int NUM_PIX = num_pix(R_I, C_I),
    localparam int W_OUT   = w_out(R_I, C_I, W_I),
    localparam int CW      = cnt_w(NUM_PIX)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_axis_pixel_valid,
    output logic             s_axis_pixel_ready,
    input  logic [W_I-1:0]   s_axis_pixel_data,
    output logic             m_axis_frame_valid,
    input  logic             m_axis_frame_ready,
    output logic [W_OUT-1:0] m_axis_frame_data,
    output logic [CW-1:0]    pix_count,
    output logic             err_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be positive");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W_OUT-1:0] data_q, data_d;
    logic             hs, last, expire;

    assign hs   = s_axis_pixel_valid && (state_q == FILL);
    assign last = (cnt_q == CW'(NUM_PIX - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        // Unwritten slots keep the previous frame's pixels.
        for (int p = 0; p < NUM_PIX; p++)
            if (hs && cnt_q == CW'(p)) data_d[p*W_I +: W_I] = s_axis_pixel_data;
        if (hs) begin
            cnt_d   = last ? '0 : cnt_q + CW'(1);
            state_d = last ? HOLD : FILL;
        end else if (state_q == HOLD && m_axis_frame_ready) begin
            state_d = FILL;
        end else if (expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign s_axis_pixel_ready = (state_q == FILL);
    assign m_axis_frame_valid = (state_q == HOLD);
    assign m_axis_frame_data  = data_q;
    assign pix_count          = cnt_q;

`ifdef FRAME_TIMEOUT_EN
    logic idle, err_q;

    assign idle = (state_q == FILL) && (cnt_q != '0) && !hs;

    frame_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk      (clk),
        .rstn     (rstn),
        .idle_i   (idle),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= expire;
    end

    assign err_timeout = err_q;
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pixel_frame_packer.sv
// tb_axis_pixel_frame_packer: randomized directed bench against a pixel-array/frame-queue reference model.
module tb_axis_pixel_frame_packer;

    localparam int NP  = 49;
    localparam int WO  = 392;
    localparam int CW  = 6;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_v = 1'b0;
    logic          s_r;
    logic [7:0]    s_d = '0;
    logic          m_v;
    logic          m_r = 1'b0;
    logic [WO-1:0] m_d;
    logic [CW-1:0] pc;
    logic          err;

    axis_pixel_frame_packer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .s_axis_pixel_valid (s_v),
        .s_axis_pixel_ready (s_r),
        .s_axis_pixel_data  (s_d),
        .m_axis_frame_valid (m_v),
        .m_axis_frame_ready (m_r),
        .m_axis_frame_data  (m_d),
        .pix_count          (pc),
        .err_timeout        (err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            mcnt = 0;
    int            rdy_low = 0;
    int            err_pulses = 0;
    int            frames = 0;
    bit            exp_err = 0;
    logic [7:0]    mbuf [NP];
    logic [WO-1:0] exp_q [$];
`ifdef FRAME_TIMEOUT_EN
    int            idle = 0;
`endif

    function automatic logic [WO-1:0] packed_buf();
        logic [WO-1:0] r;
        for (int p = 0; p < NP; p++) r[p*8 +: 8] = mbuf[p];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [WO-1:0] obs, input logic [WO-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the spec's rules, compare all outputs.
    task automatic tick(input bit v, input logic [7:0] d, input bit mr);
        bit fill, acc, fhs;
        logic [WO-1:0] pre_data;
        s_v = v;
        s_d = d;
        m_r = mr;
        fill = (exp_q.size() == 0);
        acc  = v && fill;
        fhs  = !fill && mr;
        pre_data = m_d;
        if (!s_r) rdy_low++;
        exp_err = 0;
        @(posedge clk);
        if (!rstn) begin
            mcnt = 0;
            exp_q.delete();
            for (int p = 0; p < NP; p++) mbuf[p] = '0;
`ifdef FRAME_TIMEOUT_EN
            idle = 0;
`endif
        end else begin
            if (fhs) begin
                chk("frame_out", pre_data, exp_q[0]);
                void'(exp_q.pop_front());
                frames++;
            end
            if (acc) begin
                mbuf[mcnt] = d;
                mcnt++;
                if (mcnt == NP) begin
                    exp_q.push_back(packed_buf());
                    mcnt = 0;
                end
            end
`ifdef FRAME_TIMEOUT_EN
            if (!acc && fill && mcnt > 0) begin
                idle++;
                if (idle == TMO) begin
                    mcnt = 0;
                    idle = 0;
                    exp_err = 1;
                end
            end else idle = 0;
`endif
        end
        #1;
        chk("pix_count", pc, mcnt);
        chk("m_valid", m_v, exp_q.size() > 0);
        chk("s_ready", s_r, exp_q.size() == 0);
        chk("m_data", m_d, packed_buf());
        chk("err_timeout", err, exp_err);
        if (err) err_pulses++;
    endtask

    task automatic send_pixel(input logic [7:0] d, input int gap, input bit mr);
        bit a;
        repeat (gap) tick(1'b0, 8'h00, mr);
        for (int t = 0; t < 64; t++) begin
            a = (exp_q.size() == 0);
            tick(1'b1, d, mr);
            if (a) begin
                s_v = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $error("FAIL send_bound observed=not_accepted expected=accepted");
    endtask

    function automatic logic [7:0] rnd();
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [7:0] p;
        int         n;
        for (int i = 0; i < NP; i++) mbuf[i] = '0;

        // Reset state
        rstn = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        rstn = 1'b1;
        chk("rst_pix", pc, 0);
        chk("rst_valid", m_v, 0);
        chk("rst_ready", s_r, 1);
        chk("rst_data", m_d, 0);

        // Ramp frame 0x01..0x31 back-to-back
        for (int i = 1; i <= NP; i++) send_pixel(8'(i), 0, 1'b1);
        chk("ramp_valid", m_v, 1);
        chk("ramp_lsb", m_d[7:0], 8'h01);
        chk("ramp_msb", m_d[391:384], 8'h31);
        tick(1'b0, 8'h00, 1'b1);
        chk("ramp_drained", m_v, 0);

        // Backpressure: hold frame 10 cycles while upstream holds a pixel
        for (int i = 0; i < NP; i++) send_pixel(rnd(), 0, 1'b0);
        p = rnd();
        repeat (10) tick(1'b1, p, 1'b0);
        chk("bp_ready", s_r, 0);
        chk("bp_valid", m_v, 1);
        send_pixel(p, 0, 1'b1);
        chk("bp_held_cnt", pc, 1);
        chk("bp_held_px", m_d[7:0], p);
        for (int i = 1; i < NP; i++) send_pixel(rnd(), $urandom_range(0, 3), 1'b1);
        tick(1'b0, 8'h00, 1'b1);

        // Two frames with random gaps; one ready-low cycle per frame
        rdy_low = 0;
        frames = 0;
        for (int i = 0; i < 2 * NP; i++) send_pixel(rnd(), $urandom_range(0, 2), 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        chk("gap_rdy_low", rdy_low, 2);
        chk("gap_frames", frames, 2);

        // Mid-frame reset
        for (int i = 0; i < 20; i++) send_pixel(rnd(), 0, 1'b1);
        chk("pre_rst_cnt", pc, 20);
        rstn = 1'b0;
        tick(1'b0, 8'h00, 1'b1);
        rstn = 1'b1;
        chk("rst2_pix", pc, 0);
        chk("rst2_valid", m_v, 0);
        frames = 0;
        for (int i = 0; i < NP; i++) send_pixel(rnd(), $urandom_range(0, 1), 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        chk("rst2_frames", frames, 1);

        // Partial frame left idle
        err_pulses = 0;
        for (int i = 0; i < 20; i++) send_pixel(rnd(), 0, 1'b1);
        repeat (20) tick(1'b0, 8'h00, 1'b1);
`ifdef FRAME_TIMEOUT_EN
        chk("tmo_pulses", err_pulses, 1);
        chk("tmo_pix", pc, 0);
`else
        chk("idle_pulses", err_pulses, 0);
        chk("idle_pix", pc, 20);
`endif
        frames = 0;
        n = NP - mcnt;
        for (int i = 0; i < n; i++) send_pixel(rnd(), 0, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        chk("idle_frames", frames, 1);

        // Idle one cycle short of the limit, then a pixel
        err_pulses = 0;
        for (int i = 0; i < 20; i++) send_pixel(rnd(), 0, 1'b1);
        repeat (TMO - 1) tick(1'b0, 8'h00, 1'b1);
        send_pixel(rnd(), 0, 1'b1);
        chk("short_pix", pc, 21);
        chk("short_pulses", err_pulses, 0);
        for (int i = 21; i < NP; i++) send_pixel(rnd(), 0, 1'b1);
        tick(1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
